// File: rtl/vx_csr_req_sched_pkg.sv
// Shared constants for the CSR request scheduler: requester ids, tag widths,
// and the round-robin pointer advance helper.
package VX_csr_sched_pkg;

    localparam int CSR_NUM_REQS        = 3;
    localparam int CSR_MAX_OUTSTANDING = 4;

    localparam int REQ_ID_BITS  = $clog2(CSR_NUM_REQS);
    localparam int TAG_CNT_BITS = $clog2(CSR_MAX_OUTSTANDING) + 1;

    // Fixed requester slots
    localparam int REQ_CORE = 0;
    localparam int REQ_IO   = 1;
    localparam int REQ_EXT  = 2;

    // Next round-robin start position after index cur wins, wrapping at num.
    function automatic int rr_wrap_inc(input int cur, input int num);
        if (cur + 32'sd1 >= num) begin
            return 32'sd0;
        end else begin
            return cur + 32'sd1;
        end
    endfunction

endpackage

// File: rtl/vx_csr_req_sched_chk.sv
// Protocol checker for the CSR request scheduler: a requester that has been
// selected but stalled by the CSR pipe must keep its request asserted.
module vx_csr_req_sched_chk #(
    parameter int NUM_REQS = 3
) (
    input logic                        clk,
    input logic                        reset,
    input logic                        lock,
    input logic [$clog2(NUM_REQS)-1:0] sel_lock,
    input logic [NUM_REQS-1:0]         req_valid
);

    lock_hold_a: assert property (@(posedge clk) disable iff (reset) lock |-> req_valid[sel_lock])
        else $error("vx_csr_req_sched: locked requester %0d dropped its valid", sel_lock);

endmodule

// File: rtl/vx_csr_req_sched_tag_fifo.sv
// In-order tag FIFO: remembers which requester issued each accepted CSR
// request so responses can be routed back in order.
module vx_csr_tag_fifo
    import VX_csr_sched_pkg::*;
#(
    parameter int DATAW = REQ_ID_BITS,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATAW-1:0]         push_data,
    input  logic                     pop,
    output logic [DATAW-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [DATAW-1:0] mem_r [DEPTH];
    logic             push_s;
    logic             pop_s;

    assign push_s = push && !full;
    assign pop_s  = pop && !empty;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW + 1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW + 1)'(1);
            end
        end
    end

    // Tag storage; contents are only meaningful between push and pop.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r[AW-1:0]];
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign count = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/vx_csr_req_sched.sv
// CSR request scheduler: round-robin arbitration of several requesters onto
// the single CSR pipe, with FPU-pending stall, stall lock, and in-order
// response routing through a tag FIFO.
module vx_csr_req_sched
    import VX_csr_sched_pkg::*;
#(
    parameter int NUM_REQS        = CSR_NUM_REQS,
    parameter int REQ_DATAW       = 96,
    parameter int RSP_DATAW       = 128,
    parameter int NUM_WARPS       = 4,
    parameter int MAX_OUTSTANDING = CSR_MAX_OUTSTANDING
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQS-1:0]                   req_valid,
    input  logic [NUM_REQS*REQ_DATAW-1:0]         req_data,
    input  logic [NUM_REQS*$clog2(NUM_WARPS)-1:0] req_wid,
    input  logic [NUM_REQS-1:0]                   req_is_io,
    output logic [NUM_REQS-1:0]                   req_ready,
    input  logic [NUM_WARPS-1:0]                  fpu_pending,
    output logic                                  out_valid,
    output logic [REQ_DATAW-1:0]                  out_data,
    output logic [$clog2(NUM_WARPS)-1:0]          out_wid,
    input  logic                                  out_ready,
    input  logic                                  pipe_rsp_valid,
    input  logic [RSP_DATAW-1:0]                  pipe_rsp_data,
    output logic                                  pipe_rsp_ready,
    output logic [NUM_REQS-1:0]                   rsp_valid,
    output logic [RSP_DATAW-1:0]                  rsp_data,
    input  logic [NUM_REQS-1:0]                   rsp_ready,
    output logic [$clog2(MAX_OUTSTANDING):0]      outstanding,
    output logic                                  err_orphan_rsp
);

    localparam int ID_W  = $clog2(NUM_REQS);
    localparam int WID_W = $clog2(NUM_WARPS);

    logic [ID_W-1:0]     rr_ptr_r;
    logic [ID_W-1:0]     sel_lock_r;
    logic                lock_r;
    logic                err_orphan_r;
    logic [NUM_REQS-1:0] elig_s;
    logic [ID_W-1:0]     rr_sel_s;
    logic [ID_W-1:0]     sel_s;
    logic                lock_active_s;
    logic                out_valid_s;
    logic                push_s;
    logic                pop_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [ID_W-1:0]     fifo_head_s;

    // Eligibility: IO requests bypass the FPU-pending stall of their warp.
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            elig_s[i] = req_valid[i] && (req_is_io[i] || !fpu_pending[req_wid[i*WID_W +: WID_W]]);
        end
    end

    // Round-robin scan from rr_ptr; scanning backwards lets the closest hit win.
    always_comb begin
        int idx_v;
        idx_v    = 0;
        rr_sel_s = rr_ptr_r;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            idx_v = (int'(rr_ptr_r) + k) % NUM_REQS;
            if (elig_s[idx_v]) begin
                rr_sel_s = ID_W'(idx_v);
            end else begin
                rr_sel_s = rr_sel_s;
            end
        end
    end

    // A stalled grant stays locked only while its requester keeps valid high.
    assign lock_active_s = lock_r && req_valid[sel_lock_r];
    assign sel_s         = lock_active_s ? sel_lock_r : rr_sel_s;
    assign out_valid_s   = !reset && (lock_active_s || (|elig_s)) && !fifo_full_s;
    assign push_s        = out_valid_s && out_ready;
    assign pop_s         = pipe_rsp_valid && pipe_rsp_ready;

    assign out_valid = out_valid_s;
    assign out_data  = req_data[int'(sel_s)*REQ_DATAW +: REQ_DATAW];
    assign out_wid   = req_wid[int'(sel_s)*WID_W +: WID_W];

    // Only the selected requester sees ready, and only when the pipe takes it.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            req_ready[i] = (sel_s == ID_W'(i)) && push_s;
        end
    end

    // Route the pipe response to the requester at the FIFO head.
    always_comb begin
        rsp_valid      = '0;
        pipe_rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!reset && !fifo_empty_s && (fifo_head_s == ID_W'(i))) begin
                rsp_valid[i]   = pipe_rsp_valid;
                pipe_rsp_ready = rsp_ready[i];
            end else begin
                rsp_valid[i]   = 1'b0;
                pipe_rsp_ready = pipe_rsp_ready;
            end
        end
    end

    assign rsp_data = pipe_rsp_data;

    // Arbitration state: advance rr on handshake, lock the winner on a pipe stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r   <= '0;
            lock_r     <= 1'b0;
            sel_lock_r <= '0;
        end else if (push_s) begin
            rr_ptr_r <= ID_W'(rr_wrap_inc(int'(sel_s), NUM_REQS));
            lock_r   <= 1'b0;
        end else if (out_valid_s) begin
            lock_r     <= 1'b1;
            sel_lock_r <= sel_s;
        end else begin
            lock_r <= 1'b0;
        end
    end

    // Sticky error: a response showed up with no request waiting for it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_orphan_r <= 1'b0;
        end else if (pipe_rsp_valid && fifo_empty_s) begin
            err_orphan_r <= 1'b1;
        end else begin
            err_orphan_r <= err_orphan_r;
        end
    end

    assign err_orphan_rsp = err_orphan_r;

    vx_csr_tag_fifo #(
        .DATAW (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (sel_s),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (outstanding)
    );

    vx_csr_req_sched_chk #(
        .NUM_REQS (NUM_REQS)
    ) u_chk (
        .clk       (clk),
        .reset     (reset),
        .lock      (lock_r),
        .sel_lock  (sel_lock_r),
        .req_valid (req_valid)
    );

endmodule

// File: tb/tb_vx_csr_req_sched.sv
// Directed bench for vx_csr_req_sched with a reference model and a tag
// scoreboard of expected response destinations.
module tb_vx_csr_req_sched;
    import VX_csr_sched_pkg::*;

    localparam int NR = 3;
    localparam int DW = 96;
    localparam int RW = 128;
    localparam int NW = 4;
    localparam int MO = 4;
    localparam int WW = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NR-1:0]           req_valid;
    logic [NR*DW-1:0]        req_data;
    logic [NR*WW-1:0]        req_wid;
    logic [NR-1:0]           req_is_io;
    logic [NR-1:0]           req_ready;
    logic [NW-1:0]           fpu_pending;
    logic                    out_valid;
    logic [DW-1:0]           out_data;
    logic [WW-1:0]           out_wid;
    logic                    out_ready;
    logic                    pipe_rsp_valid;
    logic [RW-1:0]           pipe_rsp_data;
    logic                    pipe_rsp_ready;
    logic [NR-1:0]           rsp_valid;
    logic [RW-1:0]           rsp_data;
    logic [NR-1:0]           rsp_ready;
    logic [TAG_CNT_BITS-1:0] outstanding;
    logic                    err_orphan_rsp;

    int checks   = 0;
    int failures = 0;
    int rr_m;
    bit lock_m;
    int lock_sel_m;
    bit orphan_m;
    int tag_q[$];
    int grant_log[$];
    int max_out;

    always #5 clk = ~clk;

    vx_csr_req_sched #(
        .NUM_REQS(NR), .REQ_DATAW(DW), .RSP_DATAW(RW), .NUM_WARPS(NW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_wid(req_wid),
        .req_is_io(req_is_io), .req_ready(req_ready), .fpu_pending(fpu_pending),
        .out_valid(out_valid), .out_data(out_data), .out_wid(out_wid), .out_ready(out_ready),
        .pipe_rsp_valid(pipe_rsp_valid), .pipe_rsp_data(pipe_rsp_data), .pipe_rsp_ready(pipe_rsp_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .outstanding(outstanding), .err_orphan_rsp(err_orphan_rsp)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pay(input int i, input int s);
        return {32'hC5A0_0000 + 32'(i), 32'(s), 32'h1234_0000 + 32'(i * 256 + s)};
    endfunction

    task automatic set_req(input int i, input bit v, input int wid, input bit io, input int s);
        req_valid[i]          = v;
        req_data[i*DW +: DW]  = v ? pay(i, s) : '0;
        req_wid[i*WW +: WW]   = WW'(wid);
        req_is_io[i]          = io;
    endtask

    // Sample at posedge+3, compare against the model, update model, advance.
    task automatic cycle();
        logic [NR-1:0] el;
        logic [NR-1:0] exp_rv;
        logic          exp_prr;
        int            sel;
        bit            lact;
        bit            ov;
        #2;
        for (int i = 0; i < NR; i++)
            el[i] = req_valid[i] && (req_is_io[i] || !fpu_pending[req_wid[i*WW +: WW]]);
        lact = lock_m && req_valid[lock_sel_m];
        sel  = lact ? lock_sel_m : -1;
        for (int k = 0; k < NR; k++)
            if (sel < 0 && el[(rr_m + k) % NR]) sel = (rr_m + k) % NR;
        ov = (sel >= 0) && (tag_q.size() < MO);
        chk("out_valid", out_valid, ov);
        chk("req_ready", req_ready, (ov && out_ready) ? (1 << sel) : 0);
        if (ov) begin
            chk("out_data", out_data, req_data[sel*DW +: DW]);
            chk("out_wid", out_wid, req_wid[sel*WW +: WW]);
        end
        chk("outstanding", outstanding, tag_q.size());
        chk("err_orphan", err_orphan_rsp, orphan_m);
        exp_rv  = '0;
        exp_prr = 1'b0;
        if (tag_q.size() > 0) begin
            exp_prr = rsp_ready[tag_q[0]];
            if (pipe_rsp_valid) exp_rv[tag_q[0]] = 1'b1;
        end
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("pipe_rsp_ready", pipe_rsp_ready, exp_prr);
        if (|exp_rv) chk("rsp_data", rsp_data, pipe_rsp_data);
        if (int'(outstanding) > max_out) max_out = int'(outstanding);
        if (pipe_rsp_valid && tag_q.size() == 0) orphan_m = 1'b1;
        if (pipe_rsp_valid && exp_prr) void'(tag_q.pop_front());
        if (ov && out_ready) begin
            grant_log.push_back(sel);
            tag_q.push_back(sel);
            rr_m   = (sel + 1) % NR;
            lock_m = 1'b0;
        end else if (ov) begin
            lock_m     = 1'b1;
            lock_sel_m = sel;
        end else begin
            lock_m = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        req_valid      = '0;
        req_data       = '0;
        pipe_rsp_valid = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_pipe_rsp_ready", pipe_rsp_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_outstanding", outstanding, '0);
        chk("rst_err_orphan", err_orphan_rsp, 1'b0);
        rr_m     = 0;
        lock_m   = 1'b0;
        orphan_m = 1'b0;
        tag_q.delete();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog expired checks=%0d", checks);
    end

    initial begin
        reset = 1'b1; req_valid = '0; req_data = '0; req_wid = '0; req_is_io = '0;
        fpu_pending = '0; out_ready = 1'b0; pipe_rsp_valid = 1'b0; pipe_rsp_data = '0;
        rsp_ready = '1; max_out = 0; lock_sel_m = 0;
        do_reset();

        // All requesters busy, responses two cycles behind the grants
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NR; i++) set_req(i, c < 6, 0, 1'b0, c);
            pipe_rsp_valid = (c >= 2);
            pipe_rsp_data  = {32'hFEED_0000, 64'h0, 32'(c)};
            cycle();
        end
        pipe_rsp_valid = 1'b0;
        chk("t1_ngrants", grant_log.size(), 6);
        for (int k = 0; k < 6; k++) chk($sformatf("t1_grant%0d", k), grant_log[k], k % 3);
        chk("t1_peak_outstanding", max_out, 2);

        // FPU-pending stall: the IO request of the same warp goes first
        grant_log.delete();
        fpu_pending = 4'b0010;
        set_req(REQ_CORE, 1'b1, 1, 1'b0, 10);
        set_req(REQ_IO, 1'b1, 1, 1'b1, 11);
        set_req(REQ_EXT, 1'b0, 0, 1'b0, 0);
        cycle();
        set_req(REQ_IO, 1'b0, 1, 1'b1, 0);
        cycle();
        #1; chk("t2_stalled_out_valid", out_valid, 1'b0);
        cycle();
        chk("t2_grants_while_stalled", grant_log.size(), 1);
        fpu_pending = 4'b0000;
        cycle();
        set_req(REQ_CORE, 1'b0, 0, 1'b0, 0);
        chk("t2_first", grant_log[0], REQ_IO);
        chk("t2_second", grant_log[1], REQ_CORE);
        pipe_rsp_valid = 1'b1; pipe_rsp_data = 128'hA5;
        cycle();
        cycle();
        pipe_rsp_valid = 1'b0;

        // Pipe stall locks req2 even when a closer rr candidate appears
        grant_log.delete();
        out_ready = 1'b0;
        set_req(REQ_CORE, 1'b1, 2, 1'b0, 20);
        set_req(REQ_EXT, 1'b1, 3, 1'b1, 22);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) set_req(REQ_IO, 1'b1, 0, 1'b0, 21);
            #1; chk($sformatf("t3_hold_data%0d", c), out_data, pay(REQ_EXT, 22));
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        set_req(REQ_EXT, 1'b0, 0, 1'b0, 0);
        cycle();
        set_req(REQ_CORE, 1'b0, 0, 1'b0, 0);
        cycle();
        set_req(REQ_IO, 1'b0, 0, 1'b0, 0);
        chk("t3_ngrants", grant_log.size(), 3);
        chk("t3_first", grant_log[0], REQ_EXT);
        chk("t3_second", grant_log[1], REQ_CORE);
        chk("t3_third", grant_log[2], REQ_IO);
        pipe_rsp_valid = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        pipe_rsp_valid = 1'b0;

        // Fill the tag FIFO, then a pop cycle must not push
        grant_log.delete();
        set_req(REQ_CORE, 1'b1, 0, 1'b0, 30);
        for (int c = 0; c < 4; c++) cycle();
        #1;
        chk("t4_full_out_valid", out_valid, 1'b0);
        chk("t4_full_outstanding", outstanding, 3'd4);
        cycle();
        pipe_rsp_valid = 1'b1;
        #1;
        chk("t4_pop_out_valid", out_valid, 1'b0);
        chk("t4_pop_req_ready", req_ready, '0);
        chk("t4_pop_pipe_rsp_ready", pipe_rsp_ready, 1'b1);
        cycle();
        pipe_rsp_valid = 1'b0;
        #1;
        chk("t4_after_pop_outstanding", outstanding, 3'd3);
        chk("t4_after_pop_out_valid", out_valid, 1'b1);
        cycle();
        chk("t4_ngrants", grant_log.size(), 5);
        set_req(REQ_CORE, 1'b0, 0, 1'b0, 0);
        pipe_rsp_valid = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        pipe_rsp_valid = 1'b0;
        #1; chk("t4_drained", outstanding, 3'd0);
        cycle();

        // Orphan response with an empty FIFO
        pipe_rsp_valid = 1'b1;
        #1;
        chk("t5_orphan_pipe_rsp_ready", pipe_rsp_ready, 1'b0);
        chk("t5_orphan_rsp_valid", rsp_valid, '0);
        cycle();
        pipe_rsp_valid = 1'b0;
        #1; chk("t5_orphan_set", err_orphan_rsp, 1'b1);
        cycle();
        cycle();
        #1; chk("t5_orphan_sticky", err_orphan_rsp, 1'b1);
        do_reset();
        #1; chk("t5_orphan_cleared", err_orphan_rsp, 1'b0);

        // Reset with tags outstanding and rr moved away from 0
        set_req(REQ_IO, 1'b1, 0, 1'b0, 40);
        for (int c = 0; c < 3; c++) cycle();
        #1; chk("t6_pre_outstanding", outstanding, 3'd3);
        do_reset();
        grant_log.delete();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, i, 1'b0, 50);
        cycle();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 0, 1'b0, 0);
        chk("t6_first_after_reset", grant_log[0], REQ_CORE);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
